// File: rtl/laser_eval_scheduler.sv
// laser_eval_scheduler
//
// Stores a frame of NPTS 4-bit (X,Y) points. It then serves evaluation requests from two
// requesters under round-robin arbitration. Each evaluation sweeps the stored frame one
// point per cycle. It counts the points that lie within RADIUS_SQ (squared distance) of
// either of two candidate centres. A point inside both circles counts once.
//
// Ports
//   CLK, RST               clock; synchronous active-high reset
//   FRAME_CLR              drop the stored frame and restart loading
//   IN_VALID, X, Y         point input, accepted only while loading
//   REQ0/REQ1              evaluation requests, held until GNT
//   R{0,1}_{A,B}{X,Y}      per-requester candidate centres, sampled in the grant cycle
//   GNT                    one-hot grant pulse
//   RES_VALID, RES_ID,     result pulse, owning requester and covered-point count
//   RES_COUNT              (ID/COUNT hold their last values between pulses)
//   LOAD_DONE              pulse in the cycle that stores the last point of a frame
//   BUSY                   high unless idle in READY
module laser_eval_scheduler #(
    parameter int unsigned NPTS      = 40,
    parameter int unsigned RADIUS_SQ = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       FRAME_CLR,
    input  logic       IN_VALID,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic [3:0] R0_AX,
    input  logic [3:0] R0_AY,
    input  logic [3:0] R0_BX,
    input  logic [3:0] R0_BY,
    input  logic [3:0] R1_AX,
    input  logic [3:0] R1_AY,
    input  logic [3:0] R1_BX,
    input  logic [3:0] R1_BY,
    output logic [1:0] GNT,
    output logic       RES_VALID,
    output logic       RES_ID,
    output logic [5:0] RES_COUNT,
    output logic       LOAD_DONE,
    output logic       BUSY
);

    localparam int unsigned IW   = $clog2(NPTS);
    localparam logic [5:0]  LAST = 6'(NPTS - 1);

    typedef enum logic [1:0] {StLoad, StReady, StSweep, StResult} state_e;

    state_e     state_q, state_d;
    logic [5:0] wr_idx_q;
    logic [5:0] idx_q;
    logic [5:0] acc_q;
    logic       prio_q;
    logic       owner_q;
    logic       res_id_q;
    logic [5:0] res_count_q;
    logic [3:0] ax_q, ay_q, bx_q, by_q;

    logic [3:0] pt_x_q [NPTS];
    logic [3:0] pt_y_q [NPTS];

    logic       store, start, grant_id, res_valid, load_done;
    logic [1:0] gnt;
    logic [8:0] d2_a, d2_b;
    logic       covered;

    // Squared distance; the 5-bit signed difference is folded to a 4-bit magnitude first
    // so the squares cannot be truncated (max 225 + 225 = 450).
    function automatic logic [8:0] dist_sq(input logic [3:0] cx, input logic [3:0] cy,
                                           input logic [3:0] px, input logic [3:0] py);
        logic [4:0] dx, dy;
        logic [3:0] mx, my;
        dx = {1'b0, cx} - {1'b0, px};
        dy = {1'b0, cy} - {1'b0, py};
        mx = dx[4] ? 4'(~dx + 5'd1) : dx[3:0];
        my = dy[4] ? 4'(~dy + 5'd1) : dy[3:0];
        return ({5'd0, mx} * {5'd0, mx}) + ({5'd0, my} * {5'd0, my});
    endfunction

    always_comb begin
        d2_a    = dist_sq(ax_q, ay_q, pt_x_q[idx_q[IW-1:0]], pt_y_q[idx_q[IW-1:0]]);
        d2_b    = dist_sq(bx_q, by_q, pt_x_q[idx_q[IW-1:0]], pt_y_q[idx_q[IW-1:0]]);
        covered = (32'(d2_a) <= RADIUS_SQ) || (32'(d2_b) <= RADIUS_SQ);
    end

    // Next state and the combinational pulses
    always_comb begin
        state_d   = state_q;
        gnt       = 2'b00;
        grant_id  = 1'b0;
        res_valid = 1'b0;
        load_done = 1'b0;
        store     = 1'b0;
        start     = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (IN_VALID) begin
                    store = 1'b1;
                    if (wr_idx_q == LAST) begin
                        load_done = 1'b1;
                        state_d   = StReady;
                    end
                end
            end
            StReady: begin
                if (REQ0 || REQ1) begin
                    start    = 1'b1;
                    grant_id = (REQ0 && REQ1) ? prio_q : REQ1;
                    gnt      = grant_id ? 2'b10 : 2'b01;
                    state_d  = StSweep;
                end
            end
            StSweep: begin
                if (idx_q == LAST) state_d = StResult;
            end
            StResult: begin
                res_valid = 1'b1;
                state_d   = StReady;
            end
            default: state_d = StLoad;
        endcase
        // Frame clear and reset abort whatever is in flight, including this cycle's pulses
        if (FRAME_CLR || RST) begin
            state_d   = StLoad;
            gnt       = 2'b00;
            res_valid = 1'b0;
            load_done = 1'b0;
            store     = 1'b0;
            start     = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StLoad;
            wr_idx_q    <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            res_id_q    <= 1'b0;
            res_count_q <= '0;
            ax_q        <= '0;
            ay_q        <= '0;
            bx_q        <= '0;
            by_q        <= '0;
        end else begin
            state_q <= state_d;
            if (FRAME_CLR) begin
                wr_idx_q <= '0;
            end else if (store) begin
                wr_idx_q <= wr_idx_q + 6'd1;
            end
            if (start) begin
                prio_q  <= ~grant_id;
                owner_q <= grant_id;
                idx_q   <= '0;
                acc_q   <= '0;
                ax_q    <= grant_id ? R1_AX : R0_AX;
                ay_q    <= grant_id ? R1_AY : R0_AY;
                bx_q    <= grant_id ? R1_BX : R0_BX;
                by_q    <= grant_id ? R1_BY : R0_BY;
            end else if (state_q == StSweep) begin
                idx_q <= idx_q + 6'd1;
                if (covered) acc_q <= acc_q + 6'd1;
            end
            if (res_valid) begin
                res_id_q    <= owner_q;
                res_count_q <= acc_q;
            end
        end
    end

    // Point buffer carries no reset; every entry is rewritten before a sweep can read it
    always_ff @(posedge CLK) begin
        if (store) begin
            pt_x_q[wr_idx_q[IW-1:0]] <= X;
            pt_y_q[wr_idx_q[IW-1:0]] <= Y;
        end
    end

    // Outputs are forced to reset values for the whole time RST is high
    always_comb begin
        GNT       = gnt;
        RES_VALID = res_valid;
        LOAD_DONE = load_done;
        RES_ID    = RST ? 1'b0 : (res_valid ? owner_q : res_id_q);
        RES_COUNT = RST ? 6'd0 : (res_valid ? acc_q : res_count_q);
        BUSY      = RST || (state_q != StReady);
    end

endmodule
